// File: rtl/bank_rd_mux_pipe_if.sv
// Bus bundle for bank_rd_mux_pipe: bank read words in, one selected word out,
// with valid/ready handshakes on both sides plus flush and the sticky error flag.
interface bank_rd_mux_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BANK_NUM   = 64,
    parameter int BANK_WIDTH = $clog2(BANK_NUM),
    parameter int TAG_WIDTH  = 10
);
    logic                           flush;
    logic [BANK_NUM*DATA_WIDTH-1:0] q_in;
    logic [BANK_WIDTH-1:0]          sel;
    logic [TAG_WIDTH-1:0]           tag_in;
    logic                           in_valid;
    logic                           in_ready;
    logic [DATA_WIDTH-1:0]          q_out;
    logic [TAG_WIDTH-1:0]           tag_out;
    logic                           out_valid;
    logic                           out_ready;
    logic                           sel_err;
    logic                           err_clr;

    modport master (
        output flush, q_in, sel, tag_in, in_valid, out_ready, err_clr,
        input  in_ready, q_out, tag_out, out_valid, sel_err
    );

    modport slave (
        input  flush, q_in, sel, tag_in, in_valid, out_ready, err_clr,
        output in_ready, q_out, tag_out, out_valid, sel_err
    );
endinterface

// File: rtl/bank_rd_mux_pipe.sv
// Pipelined BANK_NUM:1 read-word multiplexer with a sideband tag.
// STAGES=1 registers the full selection; STAGES=2 splits it into a per-group
// selection on the low select bits followed by a group selection on the high
// bits. Each stage is an elastic register; unused select codes read as zero
// and raise a sticky sel_err.
module bank_rd_mux_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int BANK_NUM   = 64,
    parameter int BANK_WIDTH = $clog2(BANK_NUM),
    parameter int STAGES     = 2,
    parameter int TAG_WIDTH  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    bank_rd_mux_pipe_if.slave bus
);
    localparam int HI_W      = BANK_WIDTH / 2;
    localparam int LO_W      = BANK_WIDTH - HI_W;
    localparam int G         = 2 ** LO_W;
    localparam int NGRP      = 2 ** HI_W;
    localparam int PAD_BANKS = 2 ** BANK_WIDTH;
    localparam int unsigned  BANK_NUM_U = BANK_NUM;
    localparam logic [BANK_WIDTH:0] BANK_LIMIT = BANK_NUM_U[BANK_WIDTH:0];

    logic [PAD_BANKS*DATA_WIDTH-1:0] q_pad_s;
    logic                  in_ready_s;
    logic                  in_fire_s;
    logic                  last_ld_s;
    logic                  last_in_valid_s;
    logic [DATA_WIDTH-1:0] last_in_data_s;
    logic [TAG_WIDTH-1:0]  last_in_tag_s;
    logic                  err_set_s;

    logic                  out_valid_d, out_valid_q;
    logic [DATA_WIDTH-1:0] q_out_d, q_out_q;
    logic [TAG_WIDTH-1:0]  tag_out_d, tag_out_q;
    logic                  sel_err_d, sel_err_q;

    // Zero-extend the bank bus to a power-of-two bank count so select codes
    // beyond BANK_NUM naturally deliver an all-zero word.
    always_comb begin
        q_pad_s = '0;
        q_pad_s[BANK_NUM*DATA_WIDTH-1:0] = bus.q_in;
    end

    // The output register may load when empty or when its word leaves now.
    assign last_ld_s = !out_valid_q || bus.out_ready;
    assign in_fire_s = bus.in_valid && in_ready_s;
    assign err_set_s = in_fire_s && ({1'b0, bus.sel} >= BANK_LIMIT);

    generate
        if (STAGES == 1) begin : g_one
            assign in_ready_s      = last_ld_s;
            assign last_in_valid_s = bus.in_valid;
            assign last_in_data_s  = q_pad_s[int'(bus.sel)*DATA_WIDTH +: DATA_WIDTH];
            assign last_in_tag_s   = bus.tag_in;
        end else begin : g_two
            logic [BANK_WIDTH:0]   sel_ext_s;
            logic [DATA_WIDTH-1:0] cand_d [NGRP];
            logic [DATA_WIDTH-1:0] cand_q [NGRP];
            logic [HI_W:0]         hi_d, hi_q;
            logic [TAG_WIDTH-1:0]  tag1_d, tag1_q;
            logic                  v1_d, v1_q;
            logic [DATA_WIDTH-1:0] grp_sel_s;

            // Extra zero MSB keeps the high-bit field at least one bit wide.
            assign sel_ext_s  = {1'b0, bus.sel};
            assign in_ready_s = !v1_q || last_ld_s;

            // Level 1: one candidate word per group, picked by the low select bits
            always_comb begin
                for (int g = 0; g < NGRP; g++) begin
                    cand_d[g] = q_pad_s[(g*G + int'(sel_ext_s[LO_W-1:0]))*DATA_WIDTH +: DATA_WIDTH];
                end
            end

            // Stage-1 next state: valid follows the elastic load rule, flush wins
            always_comb begin
                v1_d   = v1_q;
                hi_d   = hi_q;
                tag1_d = tag1_q;
                if (bus.flush) begin
                    v1_d = 1'b0;
                end else if (in_ready_s) begin
                    v1_d = bus.in_valid;
                end else begin
                    v1_d = v1_q;
                end
                if (in_fire_s) begin
                    hi_d   = sel_ext_s[BANK_WIDTH:LO_W];
                    tag1_d = bus.tag_in;
                end else begin
                    hi_d   = hi_q;
                    tag1_d = tag1_q;
                end
            end

            // Stage-1 registers; candidates only change on an accepted input
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v1_q   <= 1'b0;
                    hi_q   <= '0;
                    tag1_q <= '0;
                    for (int g = 0; g < NGRP; g++) begin
                        cand_q[g] <= '0;
                    end
                end else begin
                    v1_q   <= v1_d;
                    hi_q   <= hi_d;
                    tag1_q <= tag1_d;
                    if (in_fire_s) begin
                        for (int g = 0; g < NGRP; g++) begin
                            cand_q[g] <= cand_d[g];
                        end
                    end
                end
            end

            // Level 2: choose among registered group candidates by the high bits
            always_comb begin
                grp_sel_s = '0;
                for (int g = 0; g < NGRP; g++) begin
                    grp_sel_s = grp_sel_s | ({DATA_WIDTH{int'(hi_q) == g}} & cand_q[g]);
                end
            end

            assign last_in_valid_s = v1_q;
            assign last_in_data_s  = grp_sel_s;
            assign last_in_tag_s   = tag1_q;
        end
    endgenerate

    // Output stage and sticky error next state; a new error beats err_clr
    always_comb begin
        out_valid_d = out_valid_q;
        q_out_d     = q_out_q;
        tag_out_d   = tag_out_q;
        sel_err_d   = sel_err_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (last_ld_s) begin
            out_valid_d = last_in_valid_s;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (last_ld_s && last_in_valid_s) begin
            q_out_d   = last_in_data_s;
            tag_out_d = last_in_tag_s;
        end else begin
            q_out_d   = q_out_q;
            tag_out_d = tag_out_q;
        end
        if (err_set_s) begin
            sel_err_d = 1'b1;
        end else if (bus.err_clr) begin
            sel_err_d = 1'b0;
        end else begin
            sel_err_d = sel_err_q;
        end
    end

    // Output and error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            q_out_q     <= '0;
            tag_out_q   <= '0;
            sel_err_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            q_out_q     <= q_out_d;
            tag_out_q   <= tag_out_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.q_out     = q_out_q;
    assign bus.tag_out   = tag_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sel_err   = sel_err_q;
endmodule

// File: tb/tb_bank_rd_mux_pipe.sv
// Bench for bank_rd_mux_pipe: instance A (64 banks, two stages) and instance B
// (48 banks, one stage) are driven side by side. A queue-based reference model
// tracks accepted items, their acceptance edge and the sticky error flag.
module tb_bank_rd_mux_pipe;
    logic clk;
    logic rst_n;

    bank_rd_mux_pipe_if #(.DATA_WIDTH(32), .BANK_NUM(64), .TAG_WIDTH(10)) ifa ();
    bank_rd_mux_pipe_if #(.DATA_WIDTH(32), .BANK_NUM(48), .TAG_WIDTH(10)) ifb ();

    bank_rd_mux_pipe #(.DATA_WIDTH(32), .BANK_NUM(64), .STAGES(2), .TAG_WIDTH(10))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    bank_rd_mux_pipe #(.DATA_WIDTH(32), .BANK_NUM(48), .STAGES(1), .TAG_WIDTH(10))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    logic [31:0] bank_a [64];
    logic [31:0] bank_b [48];
    logic        drv_valid  [2];
    logic        drv_oready [2];
    logic        drv_flush  [2];
    logic        drv_clr    [2];
    logic [5:0]  drv_sel    [2];
    logic [9:0]  drv_tag    [2];

    logic        obs_ready [2];
    logic        obs_valid [2];
    logic        obs_err   [2];
    logic [31:0] obs_q     [2];
    logic [9:0]  obs_tag   [2];

    typedef struct {
        logic [31:0] data;
        logic [9:0]  tag;
        int          edge_n;
    } item_t;

    item_t mq0 [$];
    item_t mq1 [$];
    int    edges;
    bit    m_err    [2];
    bit    fire_in  [2];
    bit    fire_out [2];
    int    out_cnt  [2];
    int    n_vec;
    int    n_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        for (int k = 0; k < 64; k++) ifa.q_in[k*32 +: 32] = bank_a[k];
        for (int k = 0; k < 48; k++) ifb.q_in[k*32 +: 32] = bank_b[k];
    end

    assign ifa.in_valid = drv_valid[0];  assign ifb.in_valid = drv_valid[1];
    assign ifa.out_ready = drv_oready[0]; assign ifb.out_ready = drv_oready[1];
    assign ifa.flush = drv_flush[0];     assign ifb.flush = drv_flush[1];
    assign ifa.err_clr = drv_clr[0];     assign ifb.err_clr = drv_clr[1];
    assign ifa.sel = drv_sel[0];         assign ifb.sel = drv_sel[1];
    assign ifa.tag_in = drv_tag[0];      assign ifb.tag_in = drv_tag[1];

    assign obs_ready[0] = ifa.in_ready;  assign obs_ready[1] = ifb.in_ready;
    assign obs_valid[0] = ifa.out_valid; assign obs_valid[1] = ifb.out_valid;
    assign obs_err[0] = ifa.sel_err;     assign obs_err[1] = ifb.sel_err;
    assign obs_q[0] = ifa.q_out;         assign obs_q[1] = ifb.q_out;
    assign obs_tag[0] = ifa.tag_out;     assign obs_tag[1] = ifb.tag_out;

    function automatic int stg_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic int bnum_of(input int d);
        return (d == 0) ? 64 : 48;
    endfunction

    // Word a transfer of bank s should deliver: the bank content, or 0 when absent.
    function automatic logic [31:0] bank_word(input int d, input int s);
        if (s >= bnum_of(d)) return 32'h0000_0000;
        if (d == 0) return bank_a[s];
        return bank_b[s];
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Compare one instance against the model just before the clock edge.
    task automatic check_dut(input int d);
        item_t head;
        int    n;
        bit    ev;
        bit    er;
        ev = 1'b0;
        if (d == 0) n = mq0.size();
        else        n = mq1.size();
        if (n > 0) begin
            if (d == 0) head = mq0[0];
            else        head = mq1[0];
            ev = (edges >= head.edge_n + stg_of(d) - 1);
        end
        er = (n < stg_of(d)) || drv_oready[d];
        chk($sformatf("in_ready[%0d]", d), 64'(obs_ready[d]), 64'(er));
        chk($sformatf("out_valid[%0d]", d), 64'(obs_valid[d]), 64'(ev));
        chk($sformatf("sel_err[%0d]", d), 64'(obs_err[d]), 64'(m_err[d]));
        if (ev) begin
            chk($sformatf("q_out[%0d]", d), 64'(obs_q[d]), 64'(head.data));
            chk($sformatf("tag_out[%0d]", d), 64'(obs_tag[d]), 64'(head.tag));
        end
        fire_in[d]  = er && drv_valid[d];
        fire_out[d] = ev && drv_oready[d];
    endtask

    // Apply the effect of one clock edge to the model.
    task automatic advance();
        item_t it;
        edges++;
        for (int d = 0; d < 2; d++) begin
            it.data   = bank_word(d, int'(drv_sel[d]));
            it.tag    = drv_tag[d];
            it.edge_n = edges;
            if (fire_out[d]) out_cnt[d]++;
            if (d == 0) begin
                if (fire_out[d]) void'(mq0.pop_front());
                if (drv_flush[d]) mq0.delete();
                else if (fire_in[d]) mq0.push_back(it);
            end else begin
                if (fire_out[d]) void'(mq1.pop_front());
                if (drv_flush[d]) mq1.delete();
                else if (fire_in[d]) mq1.push_back(it);
            end
            if (fire_in[d] && int'(drv_sel[d]) >= bnum_of(d)) m_err[d] = 1'b1;
            else if (drv_clr[d]) m_err[d] = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_dut(0);
        check_dut(1);
        @(posedge clk);
        advance();
        #1;
    endtask

    task automatic idle();
        for (int d = 0; d < 2; d++) begin
            drv_valid[d] = 1'b0; drv_oready[d] = 1'b1; drv_flush[d] = 1'b0;
            drv_clr[d] = 1'b0; drv_sel[d] = 6'd0; drv_tag[d] = 10'd0;
        end
    endtask

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        for (int d = 0; d < 2; d++) begin
            m_err[d] = 1'b0; fire_in[d] = 1'b0; fire_out[d] = 1'b0;
        end
    endtask

    task automatic load_banks();
        for (int k = 0; k < 64; k++) bank_a[k] = 32'hA000_0000 + 32'(k);
        for (int k = 0; k < 48; k++) bank_b[k] = 32'hB000_0000 + 32'(k);
    endtask

    task automatic reset_checks(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_valid[%0d]", tag, d), 64'(obs_valid[d]), 64'd0);
            chk($sformatf("%s_q[%0d]", tag, d), 64'(obs_q[d]), 64'd0);
            chk($sformatf("%s_tag[%0d]", tag, d), 64'(obs_tag[d]), 64'd0);
            chk($sformatf("%s_err[%0d]", tag, d), 64'(obs_err[d]), 64'd0);
            chk($sformatf("%s_ready[%0d]", tag, d), 64'(obs_ready[d]), 64'd1);
        end
    endtask

    initial begin
        int sent;
        int cnt0;
        n_vec = 0; n_err = 0; edges = 0;
        out_cnt[0] = 0; out_cnt[1] = 0;
        rst_n = 1'b0;
        idle();
        load_banks();
        model_reset();
        #3;
        reset_checks("rst");
        #19 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rel", 64'(obs_ready[0]), 64'd1);

        // Two-cycle latency through instance A
        drv_valid[0] = 1'b1; drv_sel[0] = 6'd37; drv_tag[0] = 10'd5;
        step();
        drv_valid[0] = 1'b0;
        chk("lat_early", 64'(obs_valid[0]), 64'd0);
        step();
        chk("lat_valid", 64'(obs_valid[0]), 64'd1);
        chk("lat_q", 64'(obs_q[0]), 64'h0000_0000_A000_0025);
        chk("lat_tag", 64'(obs_tag[0]), 64'd5);
        step(); step();

        // Back-to-back stream of every select code on both instances
        for (int i = 0; i < 64; i++) begin
            for (int d = 0; d < 2; d++) begin
                drv_valid[d] = 1'b1; drv_sel[d] = 6'(i); drv_tag[d] = 10'(i + 100);
            end
            step();
        end
        idle();
        repeat (3) step();
        drv_clr[1] = 1'b1;
        step();
        drv_clr[1] = 1'b0;

        // Back-pressure on A: two accepted, then in_ready drops
        cnt0 = out_cnt[0];
        drv_valid[0] = 1'b1; drv_sel[0] = 6'd10; drv_tag[0] = 10'd10;
        step();
        drv_oready[0] = 1'b0; drv_sel[0] = 6'd11; drv_tag[0] = 10'd11;
        step();
        drv_sel[0] = 6'd12; drv_tag[0] = 10'd12;
        repeat (3) step();
        chk("bp_ready_low", 64'(obs_ready[0]), 64'd0);
        chk("bp_hold_q", 64'(obs_q[0]), 64'h0000_0000_A000_000A);
        drv_oready[0] = 1'b1;
        sent = 2;
        for (int c = 0; c < 10 && sent < 4; c++) begin
            drv_sel[0] = 6'(10 + sent); drv_tag[0] = 10'(10 + sent);
            step();
            if (fire_in[0]) sent++;
        end
        chk("bp_sent", 64'(sent), 64'd4);
        drv_valid[0] = 1'b0;
        repeat (4) step();
        chk("bp_count", 64'(out_cnt[0] - cnt0), 64'd4);

        // Out-of-range select on B (48 banks)
        drv_valid[1] = 1'b1; drv_sel[1] = 6'd50; drv_tag[1] = 10'd3;
        step();
        drv_valid[1] = 1'b0;
        chk("oor_q", 64'(obs_q[1]), 64'd0);
        chk("oor_err", 64'(obs_err[1]), 64'd1);
        repeat (3) step();
        chk("oor_hold", 64'(obs_err[1]), 64'd1);
        drv_clr[1] = 1'b1;
        step();
        drv_clr[1] = 1'b0;
        chk("oor_clr", 64'(obs_err[1]), 64'd0);
        drv_valid[1] = 1'b1; drv_sel[1] = 6'd63; drv_clr[1] = 1'b1;
        step();
        drv_valid[1] = 1'b0; drv_clr[1] = 1'b0;
        chk("oor_clr_vs_set", 64'(obs_err[1]), 64'd1);
        drv_clr[1] = 1'b1;
        step();
        drv_clr[1] = 1'b0;

        // Flush on A: two items in flight, flush with in_valid high
        drv_oready[0] = 1'b0;
        drv_valid[0] = 1'b1; drv_sel[0] = 6'd1; drv_tag[0] = 10'd1;
        step();
        drv_sel[0] = 6'd2; drv_tag[0] = 10'd2;
        step();
        drv_flush[0] = 1'b1; drv_sel[0] = 6'd3; drv_tag[0] = 10'd3;
        step();
        drv_flush[0] = 1'b0; drv_valid[0] = 1'b0; drv_oready[0] = 1'b1;
        repeat (3) begin
            step();
            chk("flush_quiet", 64'(obs_valid[0]), 64'd0);
        end
        drv_flush[0] = 1'b1; drv_valid[0] = 1'b1; drv_sel[0] = 6'd4;
        step();
        drv_flush[0] = 1'b0; drv_valid[0] = 1'b0;
        repeat (3) begin
            step();
            chk("flush_discard", 64'(obs_valid[0]), 64'd0);
        end
        drv_valid[0] = 1'b1; drv_sel[0] = 6'd5; drv_tag[0] = 10'd55;
        step();
        drv_valid[0] = 1'b0;
        step();
        chk("post_flush_valid", 64'(obs_valid[0]), 64'd1);
        chk("post_flush_q", 64'(obs_q[0]), 64'h0000_0000_A000_0005);
        step();

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 2; d++) begin
                drv_valid[d]  = ($urandom_range(0, 9) < 7);
                drv_oready[d] = ($urandom_range(0, 9) < 7);
                drv_flush[d]  = ($urandom_range(0, 31) == 0);
                drv_clr[d]    = ($urandom_range(0, 15) == 0);
                drv_sel[d]    = 6'($urandom_range(0, 63));
                drv_tag[d]    = 10'($urandom);
            end
            bank_a[$urandom_range(0, 63)] = $urandom;
            bank_b[$urandom_range(0, 47)] = $urandom;
            step();
        end

        // Asynchronous reset in the middle of a stream
        idle();
        load_banks();
        repeat (3) step();
        drv_valid[0] = 1'b1; drv_sel[0] = 6'd7;
        drv_valid[1] = 1'b1; drv_sel[1] = 6'd55;
        step(); step();
        chk("pre_rst_valid", 64'(obs_valid[0]), 64'd1);
        chk("pre_rst_err", 64'(obs_err[1]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        reset_checks("async_rst");
        idle();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_ready_a", 64'(obs_ready[0]), 64'd1);
        chk("rel_ready_b", 64'(obs_ready[1]), 64'd1);
        drv_valid[0] = 1'b1; drv_sel[0] = 6'd9; drv_tag[0] = 10'd9;
        step();
        drv_valid[0] = 1'b0;
        step();
        chk("recover_q", 64'(obs_q[0]), 64'h0000_0000_A000_0009);
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/bank_rd_mux_pipe.md
BANK_RD_MUX_PIPE -- requirements
Module: bank_rd_mux_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of one bank read word.
REQ-002 SHALL have parameter BANK_NUM, default 64: number of bank inputs, legal range 2..256.
REQ-003 SHALL have parameter BANK_WIDTH, default $clog2(BANK_NUM): select width.
REQ-004 SHALL have parameter STAGES, default 2: pipeline depth, legal values 1 or 2.
REQ-005 SHALL have parameter TAG_WIDTH, default 10: width of the sideband tag, for example the FFT sample index.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port flush, input, 1 bit: synchronous clear of all pipeline valid bits.
REQ-009 SHALL have port q_in, input, BANK_NUM*DATA_WIDTH bits: bank k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port sel, input, BANK_WIDTH bits: bank index.
REQ-011 SHALL have port tag_in, input, TAG_WIDTH bits: sideband carried alongside the data.
REQ-012 SHALL have port in_valid, input, 1 bit; and port in_ready, output, 1 bit.
REQ-013 SHALL have port q_out, output, DATA_WIDTH bits: selected word.
REQ-014 SHALL have port tag_out, output, TAG_WIDTH bits.
REQ-015 SHALL have port out_valid, output, 1 bit; and port out_ready, input, 1 bit.
REQ-016 SHALL have port sel_err, output, 1 bit: sticky out-of-range flag.
REQ-017 SHALL have port err_clr, input, 1 bit: clears sel_err.

Function
REQ-018 SHALL transfer in on in_valid&&in_ready, and out on out_valid&&out_ready.
REQ-019 SHALL, with STAGES=1, register the full BANK_NUM:1 selection; latency is 1 cycle from input transfer to out_valid.
REQ-020 SHALL, with STAGES=2, split selection into two registered levels; latency is 2 cycles.
- Stage 1: select within groups of G=2^ceil(BANK_WIDTH/2) banks using sel low bits, and register one candidate per group plus sel high bits, tag and valid.
- Stage 2: select among the groups using the registered high bits.
REQ-021 SHALL treat each stage as an elastic register: a stage loads when it is empty or its contents leave in the same cycle; otherwise it holds data, tag and valid unchanged.
REQ-022 SHALL drive in_ready = !v1 || (stage 1 drains this cycle), combinationally from downstream state; in_ready SHALL NOT depend on in_valid.
REQ-023 SHALL sustain full throughput (one transfer per cycle) while out_ready=1, with no bubbles.
REQ-024 SHALL, for sel >= BANK_NUM (non-power-of-two BANK_NUM only), deliver q_out=0 for that transfer, and set sel_err on the input transfer cycle.
REQ-025 SHALL keep sel_err set until err_clr; if err_clr coincides with a new error, sel_err SHALL remain 1.
REQ-026 SHALL, on flush, clear every valid bit at the next edge, with any same-cycle input transfer discarded; data registers need not clear, and sel_err is unaffected.
REQ-027 SHALL keep q_out/tag_out stable while out_valid=1 and out_ready=0.
REQ-028 SHALL drive q_out and tag_out from registers only; there is no combinational path from q_in to q_out.

Reset
REQ-029 SHALL, on rst_n low, immediately clear all valid bits, sel_err, q_out, tag_out and internal data registers to 0, regardless of clock.
REQ-030 SHALL hold in_ready=1 during reset and in the first cycle after release; in-flight data is dropped.

Verification
REQ-031 Latency: STAGES=2, DATA_WIDTH=32, bank k holds 32'hA000_0000+k; drive sel=37, tag=5 for one cycle with out_ready=1 -> out_valid exactly 2 cycles later with q_out=32'hA000_0025, tag_out=5.
REQ-032 Streaming: sel=0..63 on consecutive cycles with out_ready=1 -> 64 consecutive outputs in order, no gaps, in_ready constant 1.
REQ-033 Back-pressure: stream sel=10,11,12,13 with out_ready=0 from cycle 2 -> in_ready falls after 2 accepted; out_ready=1 releases 10,11,12,13 in order with none lost or duplicated.
REQ-034 Out of range: BANK_NUM=48, sel=50 -> q_out=0, sel_err=1 held; err_clr pulse -> sel_err=0; err_clr together with sel=63 -> sel_err stays 1.
REQ-035 Flush: 2 items in flight plus a flush with in_valid=1 -> no outputs emerge; the next input emerges normally after 2 cycles.
REQ-036 Reset mid-stream: assert rst_n=0 between clock edges while out_valid=1 -> out_valid, q_out and sel_err become 0 without waiting for a clock edge.
